// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: hunts a 2-byte header, collects a length-prefixed payload with checksum, holds it until acked
module uart_rx_frame_parser #(
    parameter logic [7:0] HEAD0        = 8'h55,
    parameter logic [7:0] HEAD1        = 8'hAA,
    parameter int         MAX_LEN      = 16,
    parameter int         LEN_W        = 5,
    parameter int         TIMEOUT_CLKS = 104160
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_done_i,
    input  logic             frame_ack_i,
    input  logic [LEN_W-1:0] rd_addr_i,
    output logic [7:0]       rd_data_o,
    output logic             frame_rdy_o,
    output logic [LEN_W-1:0] frame_len_o,
    output logic             frame_err_o,
    output logic [1:0]       err_code_o,
    output logic             drop_o,
    output logic             busy_o
);
    typedef enum logic [2:0] {IDLE, H1, LEN, DATA, CSUM, HOLD} state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    state_t           state_q, state_d;
    logic             done_q, acc, timeout, abort;
    logic [1:0]       code_d;
    logic [CNT_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q, idx_q;
    logic [7:0]       sum_q;
    logic [7:0]       buf_q [0:(1<<LEN_W)-1];
    assign acc         = rx_done_i & ~done_q;
    assign busy_o      = state_q inside {H1, LEN, DATA, CSUM};
    assign frame_rdy_o = state_q == HOLD;
    assign timeout     = busy_o && !acc && cnt_q == CNT_W'(TIMEOUT_CLKS);
    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // next state and abort decision; an accepted byte always beats the timeout
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        code_d  = 2'b00;
        if (state_q == HOLD && frame_ack_i) state_d = IDLE;
        if (timeout) begin
            state_d = IDLE;
            abort   = 1'b1;
            code_d  = 2'b11;
        end else if (acc) begin
            case (state_q)
                IDLE: state_d = rx_data_i == HEAD0 ? H1 : IDLE;
                H1:   state_d = rx_data_i == HEAD1 ? LEN : rx_data_i == HEAD0 ? H1 : IDLE;
                LEN: begin
                    abort   = rx_data_i == 8'd0 || rx_data_i > 8'(MAX_LEN);
                    code_d  = 2'b10;
                    state_d = abort ? IDLE : DATA;
                end
                DATA: state_d = idx_q == len_q - 1'b1 ? CSUM : DATA;
                CSUM: begin
                    abort   = rx_data_i != sum_q;
                    code_d  = 2'b01;
                    state_d = abort ? IDLE : HOLD;
                end
                HOLD:    ;
                default: state_d = IDLE;
            endcase
        end
    end
    // datapath: edge detect, timeout counter, length/sum/index, status pulses, read port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q      <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            frame_len_o <= '0;
            frame_err_o <= 1'b0;
            err_code_o  <= 2'b00;
            drop_o      <= 1'b0;
            rd_data_o   <= 8'h00;
        end else begin
            done_q      <= rx_done_i;
            cnt_q       <= (acc || !busy_o) ? '0 : cnt_q + 1'b1;
            frame_err_o <= abort;
            drop_o      <= acc && state_q == HOLD;
            rd_data_o   <= rd_addr_i < LEN_W'(MAX_LEN) ? buf_q[rd_addr_i] : 8'h00;
            if (abort) err_code_o <= code_d;
            if (acc && state_q == LEN) begin
                len_q <= rx_data_i[LEN_W-1:0];
                sum_q <= rx_data_i;
                idx_q <= '0;
            end
            if (acc && state_q == DATA) begin
                sum_q <= sum_q + rx_data_i;
                idx_q <= idx_q + 1'b1;
            end
            if (acc && state_q == CSUM && !abort) frame_len_o <= len_q;
        end
    end
    // payload buffer, written only while collecting so a held frame stays frozen
    always_ff @(posedge clk_i) begin
        if (!rst_i && acc && state_q == DATA) buf_q[idx_q] <= rx_data_i;
    end
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser: directed and randomized frames checked against a frame-level model
module tb_uart_rx_frame_parser;
    localparam int T  = 60;
    localparam int ML = 16;
    localparam int LW = 5;
    logic          clk_i = 1'b0, rst_i = 1'b1, rx_done_i = 1'b0, frame_ack_i = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic [LW-1:0] rd_addr_i = '0;
    logic [7:0]    rd_data_o;
    logic          frame_rdy_o, frame_err_o, drop_o, busy_o;
    logic [LW-1:0] frame_len_o;
    logic [1:0]    err_code_o;
    int vectors = 0, miscompares = 0, cyc = 0, err_cnt = 0, drop_cnt = 0, err_cyc = 0, last_acc = 0;
    int e0, d0;
    logic [7:0] fr[$];
    logic [7:0] exp_buf[$];

    uart_rx_frame_parser #(.HEAD0(8'h55), .HEAD1(8'hAA), .MAX_LEN(ML), .LEN_W(LW), .TIMEOUT_CLKS(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
        .frame_ack_i(frame_ack_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .frame_rdy_o(frame_rdy_o), .frame_len_o(frame_len_o), .frame_err_o(frame_err_o),
        .err_code_o(err_code_o), .drop_o(drop_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        if (frame_err_o) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (drop_o) drop_cnt = drop_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i); #1 rx_data_i = b; rx_done_i = 1'b1;
        @(posedge clk_i); #1 last_acc = cyc;
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
        #1 rx_done_i = 1'b0; rx_data_i = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
    endtask

    task automatic send_fr();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic make_frame(input int len, input bit bad);
        int s;
        logic [7:0] b;
        exp_buf.delete();
        fr = '{8'h55, 8'hAA, 8'(len)};
        s = len;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            exp_buf.push_back(b);
            fr.push_back(b);
            s += int'(b);
        end
        fr.push_back(bad ? 8'(s) ^ 8'($urandom_range(1, 255)) : 8'(s));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_buf();
        foreach (exp_buf[i]) begin
            @(posedge clk_i); #1 rd_addr_i = LW'(i);
            @(posedge clk_i);
            @(negedge clk_i);
            chk("rd_data", 32'(rd_data_o), 32'(exp_buf[i]));
        end
    endtask

    task automatic ack();
        @(posedge clk_i); #1 frame_ack_i = 1'b1;
        @(posedge clk_i); #1 frame_ack_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic expect_good(input string tag);
        chk({tag, "_rdy"}, 32'(frame_rdy_o), 32'd1);
        chk({tag, "_len"}, 32'(frame_len_o), 32'(exp_buf.size()));
        chk({tag, "_errs"}, 32'(err_cnt), 32'(e0));
        check_buf();
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_rdy", 32'(frame_rdy_o), 32'd0);
        chk("rst_len", 32'(frame_len_o), 32'd0);
        chk("rst_err", 32'(frame_err_o), 32'd0);
        chk("rst_code", 32'(err_code_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rd", 32'(rd_data_o), 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        e0 = err_cnt;
        fr = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        exp_buf = '{8'h11, 8'h22, 8'h33};
        send_fr(); settle();
        expect_good("t1");
        chk("t1_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1 rd_addr_i = LW'(20);
        @(posedge clk_i); @(negedge clk_i);
        chk("rd_oob", 32'(rd_data_o), 32'd0);
        ack();
        chk("t1_ack", 32'(frame_rdy_o), 32'd0);

        e0 = err_cnt;
        fr = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00};
        send_fr(); settle();
        chk("t2_errs", 32'(err_cnt), 32'(e0 + 1));
        chk("t2_code", 32'(err_code_o), 32'd1);
        chk("t2_rdy", 32'(frame_rdy_o), 32'd0);

        e0 = err_cnt;
        fr = '{8'h55, 8'hAA, 8'h00};
        send_fr(); settle();
        chk("t3a_errs", 32'(err_cnt), 32'(e0 + 1));
        chk("t3a_code", 32'(err_code_o), 32'd2);
        fr = '{8'h55, 8'hAA, 8'h11};
        send_fr(); settle();
        chk("t3b_errs", 32'(err_cnt), 32'(e0 + 2));
        chk("t3b_code", 32'(err_code_o), 32'd2);
        chk("t3_busy", 32'(busy_o), 32'd0);

        e0 = err_cnt;
        fr = '{8'h55, 8'hAA, 8'h02, 8'h01};
        send_fr();
        for (int k = 0; k < 3 * T && err_cnt == e0; k++) @(posedge clk_i);
        @(negedge clk_i);
        chk("t4_errs", 32'(err_cnt), 32'(e0 + 1));
        chk("t4_delay", 32'(err_cyc - last_acc), 32'(T + 1));
        chk("t4_code", 32'(err_code_o), 32'd3);
        chk("t4_busy", 32'(busy_o), 32'd0);

        e0 = err_cnt;
        fr = '{8'h55, 8'hAA, 8'h02, 8'hA1, 8'hB2, 8'h55};
        exp_buf = '{8'hA1, 8'hB2};
        send_fr(); settle();
        d0 = drop_cnt;
        fr = '{8'h55, 8'hAA, 8'h01, 8'h05, 8'h06};
        send_fr(); settle();
        chk("t5_drops", 32'(drop_cnt), 32'(d0 + 5));
        expect_good("t5_held");
        ack();
        chk("t5_ack", 32'(frame_rdy_o), 32'd0);
        exp_buf = '{8'h05};
        send_fr(); settle();
        expect_good("t5_next");

        d0 = drop_cnt;
        @(posedge clk_i); #1 rx_data_i = 8'h12; rx_done_i = 1'b1; frame_ack_i = 1'b1;
        @(posedge clk_i); #1 rx_done_i = 1'b0; frame_ack_i = 1'b0;
        settle();
        chk("ackbyte_drop", 32'(drop_cnt), 32'(d0 + 1));
        chk("ackbyte_rdy", 32'(frame_rdy_o), 32'd0);

        e0 = err_cnt;
        fr = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
        exp_buf = '{8'h7F};
        send_fr(); settle();
        expect_good("t6");
        ack();

        e0 = err_cnt;
        fr = '{8'h55, 8'hAA, 8'h04, 8'h01, 8'h02};
        send_fr();
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_rdy", 32'(frame_rdy_o), 32'd0);
        chk("mrst_code", 32'(err_code_o), 32'd0);
        repeat (T + 10) @(posedge clk_i);
        @(negedge clk_i);
        chk("mrst_errs", 32'(err_cnt), 32'(e0));

        for (int n = 0; n < 20; n++) begin
            bit bad;
            int len;
            bad = (n != 0) && ($urandom_range(0, 3) == 0);
            len = (n == 0) ? ML : int'($urandom_range(1, ML));
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 8'h54)));
            e0 = err_cnt;
            make_frame(len, bad);
            send_fr(); settle();
            if (bad) begin
                chk("rnd_bad_errs", 32'(err_cnt), 32'(e0 + 1));
                chk("rnd_bad_code", 32'(err_code_o), 32'd1);
                chk("rnd_bad_rdy", 32'(frame_rdy_o), 32'd0);
            end else begin
                expect_good("rnd");
                ack();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
